// File: rtl/alu_uart_ctrl.sv
// Sequencer between a byte UART and a registered-output ALU: collects A, B and opcode, then returns the result byte.
// Optional macro ALU_CTRL_OVF_BYTE_EN appends a second byte carrying the stored ALU overflow flag.
module alu_uart_ctrl #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned OP_W           = 6,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_tx_done,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_ovf,
    output logic [DATA_W-1:0] o_alu_A,
    output logic [DATA_W-1:0] o_alu_B,
    output logic [OP_W-1:0]   o_alu_Op,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_busy
);

    localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_GET_A,
        S_GET_B,
        S_GET_OP,
        S_EXEC,
        S_CAPTURE,
        S_SEND
`ifdef ALU_CTRL_OVF_BYTE_EN
        , S_SEND_OVF
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout;

`ifdef ALU_CTRL_OVF_BYTE_EN
    logic              ovf_q, ovf_d;
`else
    logic              unused_ovf;
    assign unused_ovf = i_alu_ovf;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_GET_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            cnt_q      <= '0;
`ifdef ALU_CTRL_OVF_BYTE_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            cnt_q      <= cnt_d;
`ifdef ALU_CTRL_OVF_BYTE_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        cnt_d      = cnt_q;
        timeout    = (cnt_q == CNT_LAST);
`ifdef ALU_CTRL_OVF_BYTE_EN
        ovf_d      = ovf_q;
`endif
        case (state_q)
            S_GET_A: begin
                cnt_d = '0;
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = S_GET_B;
                end
            end
            // An arriving byte takes priority over a coincident timeout.
            S_GET_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    cnt_d   = '0;
                    state_d = S_GET_OP;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = S_GET_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GET_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[OP_W-1:0];
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = S_GET_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: state_d = S_CAPTURE;
            S_CAPTURE: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
`ifdef ALU_CTRL_OVF_BYTE_EN
                ovf_d      = i_alu_ovf;
`endif
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (i_tx_done) begin
`ifdef ALU_CTRL_OVF_BYTE_EN
                    tx_data_d  = {{(DATA_W-1){1'b0}}, ovf_q};
                    tx_start_d = 1'b1;
                    state_d    = S_SEND_OVF;
`else
                    state_d    = S_GET_A;
`endif
                end
            end
`ifdef ALU_CTRL_OVF_BYTE_EN
            S_SEND_OVF: begin
                if (i_tx_done) state_d = S_GET_A;
            end
`endif
            default: state_d = S_GET_A;
        endcase
    end

    assign o_alu_A    = a_q;
    assign o_alu_B    = b_q;
    assign o_alu_Op   = op_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = !(state_q inside {S_GET_A, S_GET_B, S_GET_OP});

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: random and directed frames, expected bytes from a behavioural ALU model.
module tb_alu_uart_ctrl;

    localparam int TO = 16;
`ifdef ALU_CTRL_OVF_BYTE_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n, rx_done, tx_done, alu_ovf, tx_start, busy;
    logic [7:0] rx_data, alu_res, alu_A, alu_B, tx_data;
    logic [5:0] alu_Op;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_uart_ctrl #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYCLES(TO)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_tx_done(tx_done), .i_alu_result(alu_res), .i_alu_ovf(alu_ovf),
        .o_alu_A(alu_A), .o_alu_B(alu_B), .o_alu_Op(alu_Op),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy)
    );

    // Reference ALU: {overflow, result} from signed integer arithmetic.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int s;
        case (op)
            6'h20: s = int'($signed(a)) + int'($signed(b));
            6'h22: s = int'($signed(a)) - int'($signed(b));
            6'h24: return {1'b0, a & b};
            6'h25: return {1'b0, a | b};
            6'h26: return {1'b0, a ^ b};
            6'h27: return {1'b0, ~(a | b)};
            default: return 9'd0;
        endcase
        return {(s > 127 || s < -128), 8'(s)};
    endfunction

    // ALU stand-in with one clock of result latency.
    always @(posedge clk) {alu_ovf, alu_res} <= alu_ref(alu_A, alu_B, alu_Op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each tx_start and checks data holds until tx_done.
    logic [7:0] held;
    bit active = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            active = 0;
        end else if (tx_start) begin
            check("tx_busy", busy, 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got tx_start with data 0x%0h, required no start", tx_data);
            end else begin
                check("tx_data", tx_data, exp_q.pop_front());
            end
            held   = tx_data;
            active = 1;
        end else if (active) begin
            check("tx_hold", tx_data, held);
            if (tx_done) active = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_done = 1'b1;
        rx_data = d;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic push_expected(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        logic [8:0] r;
        r = alu_ref(a, b, op[5:0]);
        exp_q.push_back(r[7:0]);
        if (NB == 2) exp_q.push_back({7'd0, r[8]});
    endtask

    // Called at the falling edge right after the opcode byte was sampled.
    task automatic finish_frame(input bit inject);
        for (int n = 0; n < NB; n++) begin
            int cyc = 0;
            int d;
            while (!tx_start && cyc < 12) begin
                @(negedge clk);
                cyc++;
            end
            if (!tx_start) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_start_timeout: none after %0d cycles, required a pulse", cyc);
                return;
            end
            if (n == 0) check("tx_latency", cyc, 2);
            d = inject ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            repeat (d) begin
                if (inject) begin
                    rx_done = 1'b1;
                    rx_data = 8'hAA;
                end
                @(negedge clk);
            end
            tx_done = 1'b1;
            rx_done = inject;
            rx_data = 8'hAA;
            @(negedge clk);
            tx_done = 1'b0;
            rx_done = 1'b0;
        end
        check("busy_idle", busy, 0);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit inject);
        send_byte(a);
        idle($urandom_range(0, 3));
        send_byte(b);
        idle($urandom_range(0, 3));
        push_expected(a, b, op);
        send_byte(op);
        check("alu_A", alu_A, a);
        check("alu_B", alu_B, b);
        check("alu_Op", alu_Op, op[5:0]);
        check("busy_exec", busy, 1);
        finish_frame(inject);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_A"}, alu_A, 0);
        check({tag, "_B"}, alu_B, 0);
        check({tag, "_Op"}, alu_Op, 0);
        check({tag, "_txd"}, tx_data, 0);
        check({tag, "_txs"}, tx_start, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [5:0] ops[6];
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
        rst_n = 1'b0; rx_done = 1'b0; rx_data = '0; tx_done = 1'b0;
        idle(3);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(8'h05, 8'h03, 8'h20, 0);
        run_frame(8'h80, 8'h01, 8'h22, 0);

        // Inter-byte timeout abort, then a clean frame.
        send_byte(8'h05);
        idle(TO);
        check("timeout_busy", busy, 0);
        check("timeout_keepA", alu_A, 8'h05);
        run_frame(8'h0F, 8'h03, 8'h24, 0);

        // Byte arriving on the timeout edge is accepted.
        send_byte(8'h05);
        idle(TO - 1);
        send_byte(8'h07);
        push_expected(8'h05, 8'h07, 8'h20);
        send_byte(8'h20);
        check("edge_A", alu_A, 8'h05);
        check("edge_B", alu_B, 8'h07);
        finish_frame(0);

        // Stray bytes during transmit are dropped.
        run_frame(8'h11, 8'h22, 8'h25, 1);
        run_frame(8'h0C, 8'h0A, 8'h26, 0);

        // Reset while waiting for the opcode.
        send_byte(8'h09);
        send_byte(8'h07);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        run_frame(8'h33, 8'h44, 8'h20, 0);

        run_frame(8'hF0, 8'h02, 8'hE3, 0);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] op;
            op = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 5)]};
            if ($urandom_range(0, 4) == 0) op = 8'($urandom);
            run_frame(8'($urandom), 8'($urandom), op, $urandom_range(0, 3) == 0);
        end

        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
Sequencer between a byte-oriented UART (rx/tx) and the registered-output ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives them onto the ALU inputs and waits the ALU's one-clock result latency.
- Captures the result and hands it to the UART transmitter with a start/done handshake.
- Sits at the top of the ALU test design, between the uart_rx/uart_tx instances and the ALU.

Parameters:
DATA_W, 8, operand/result width; equals UART byte width.
OP_W, 6, ALU opcode width; must be <= DATA_W.
TIMEOUT_CYCLES, 50000000, max idle clocks between bytes of one frame before abort; must be >= 1.

Ports:
i_clock  input  1  system clock, rising-edge.
i_reset_n  input  1  asynchronous active-low reset.
i_rx_done  input  1  one-clock pulse: i_rx_data valid.
i_rx_data  input  DATA_W  received byte.
i_tx_done  input  1  one-clock pulse: transmitter finished the current byte.
i_alu_result  input  DATA_W  ALU registered result.
i_alu_ovf  input  1  ALU registered overflow flag.
o_alu_A  output  DATA_W  operand A to ALU.
o_alu_B  output  DATA_W  operand B to ALU.
o_alu_Op  output  OP_W  opcode to ALU.
o_tx_start  output  1  one-clock pulse: start transmitting o_tx_data.
o_tx_data  output  DATA_W  byte to transmit, stable from the o_tx_start cycle until i_tx_done.
o_busy  output  1  high while a frame is executing or transmitting.

Behaviour:
- Reset (async, i_reset_n=0): state GET_A; o_alu_A, o_alu_B, o_alu_Op, o_tx_data, timeout counter = 0; o_tx_start = 0; o_busy = 0.
  - Reset mid-operation aborts immediately, with no pending tx_start.
- States and transitions:
  - GET_A: on i_rx_done, o_alu_A <= i_rx_data; go to GET_B.
  - GET_B: on i_rx_done, o_alu_B <= i_rx_data; go to GET_OP.
  - GET_OP: on i_rx_done, o_alu_Op <= i_rx_data[OP_W-1:0] (upper bits discarded); go to EXEC.
  - EXEC: one cycle; ALU registers its result at this edge; go to CAPTURE.
  - CAPTURE: o_tx_data <= i_alu_result; o_tx_start <= 1 for exactly one clock; store i_alu_ovf internally; go to SEND.
  - SEND: wait for i_tx_done, then go to GET_A.
- Latency: opcode byte sampled at edge k → o_tx_start high after edge k+2 with the result of (A, B, Op).
- o_alu_A, o_alu_B and o_alu_Op hold their values until overwritten by the next frame.
- o_busy = 1 in EXEC, CAPTURE and SEND (and SEND_OVF when enabled); 0 otherwise.
- i_rx_done pulses in EXEC, CAPTURE, SEND or SEND_OVF are dropped. This includes the edge on which i_tx_done is accepted; there is no buffering.
- Timeout:
  - Counter clears on every accepted byte and in GET_A.
  - Counter increments each clock in GET_B and GET_OP.
  - When it reaches TIMEOUT_CYCLES-1 without i_rx_done, go to GET_A; operand registers keep their values.
  - If i_rx_done arrives on the same edge as the timeout, the byte wins (it is accepted and no abort occurs).
- i_tx_done outside SEND/SEND_OVF is ignored.

Optional Feature:
Macro ALU_CTRL_OVF_BYTE_EN.
- Defined: on i_tx_done in SEND, go to SEND_OVF. SEND_OVF sets o_tx_data <= {DATA_W-1 zeros, stored ovf}, pulses o_tx_start for one clock, waits for i_tx_done, then goes to GET_A. Each frame returns 2 bytes.
- Undefined: SEND_OVF does not exist; one result byte per frame; i_alu_ovf is unused.

Test Plan:
1. Bytes 0x05, 0x03, 0x20 (ADD) → o_alu_Op=0x20 after edge k; o_tx_start single pulse after edge k+2 with o_tx_data=0x08; o_busy high until i_tx_done.
2. ALU_CTRL_OVF_BYTE_EN defined, bytes 0x80, 0x01, 0x22 (SUB) → two tx bytes: 0x7F then 0x01; without the macro, only 0x7F.
3. TIMEOUT_CYCLES=16, send 0x05 then nothing for 16 clocks → back in GET_A; then send 0x0F, 0x03, 0x24 → result 0x03 transmitted.
4. Extra i_rx_done (0xAA) during SEND, plus one coincident with i_tx_done → both dropped; next frame 0x0C, 0x0A, 0x26 → 0x06.
5. i_reset_n low for 2 clocks while in GET_OP → all outputs 0, o_tx_start never pulses; next full frame works normally.
6. Opcode byte 0xE3 with A=0xF0, B=0x02 → o_alu_Op=0x23; SRL-free opcode is not an ALU op, so the ALU default gives result 0x00, transmitted as 0x00.
